// File: rtl/cbm2_busarb.sv
// cbm2_busarb: arbitrates CHANNELS bus masters onto one shared variable-latency memory port.
// Latency: grant in the IDLE cycle req is seen, mem_req the next cycle, ack/rdata one cycle after mem_ready.
// Backpressure: masters hold req until ack; memory stalls via mem_ready (CBM2_BUSARB_TIMEOUT_EN adds abort).
`timescale 1ns/1ps
module cbm2_busarb #(
  parameter int CHANNELS   = 3,
  parameter int AW         = 25,
  parameter int DW         = 8,
  parameter int RR         = 1,
  parameter int TMO_CYCLES = 15
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [CHANNELS-1:0]    req,
  input  logic [CHANNELS-1:0]    we,
  input  logic [CHANNELS*AW-1:0] addr,
  input  logic [CHANNELS*DW-1:0] wdata,
  output logic [CHANNELS-1:0]    ack,
  output logic [CHANNELS*DW-1:0] rdata,
  output logic [CHANNELS-1:0]    err,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ready,
  input  logic [DW-1:0]          mem_rdata
);

  localparam int IW = $clog2(CHANNELS);

  // Reject configurations the datapath was not sized for.
  if (CHANNELS < 2 || CHANNELS > 8 || TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_cfg_check
    $error("cbm2_busarb: CHANNELS must be 2..8 and TMO_CYCLES 1..255");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [IW-1:0]                last_q, last_d;     // round-robin pointer: last granted channel
  logic [IW-1:0]                gnt_q, gnt_d;       // channel owning the current access
  logic                         mem_we_q, mem_we_d;
  logic [AW-1:0]                mem_addr_q, mem_addr_d;
  logic [DW-1:0]                mem_wdata_q, mem_wdata_d;
  logic [CHANNELS-1:0]          ack_q, ack_d;
  logic [CHANNELS-1:0][DW-1:0]  rdata_q, rdata_d;

  logic [CHANNELS-1:0]          elig;
  logic                         win_vld;
  logic [IW-1:0]                win_idx;
  int                           rr_pos;
  logic                         tmo_hit;

  // Winner selection; a channel being acked right now is excluded so its stale req is not re-granted.
  always_comb begin
    elig    = req & ~ack_q;
    win_vld = 1'b0;
    win_idx = '0;
    rr_pos  = 0;
    if (RR != 0) begin
      for (int i = 1; i <= CHANNELS; i++) begin
        rr_pos = int'(last_q) + i;
        if (rr_pos >= CHANNELS) rr_pos = rr_pos - CHANNELS;
        if (!win_vld && elig[rr_pos]) begin
          win_vld = 1'b1;
          win_idx = IW'(rr_pos);
        end
      end
    end else begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (elig[i]) begin
          win_vld = 1'b1;
          win_idx = IW'(i);
        end
      end
    end
  end

  // Next-state logic: grant in IDLE, complete (or abort) in BUSY, ack one cycle later.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d     = BUSY;
          gnt_d       = win_idx;
          last_d      = win_idx;
          mem_we_d    = we[win_idx];
          mem_addr_d  = addr[int'(win_idx)*AW +: AW];
          mem_wdata_d = wdata[int'(win_idx)*DW +: DW];
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d        = IDLE;
          ack_d[gnt_q]   = 1'b1;
          if (!mem_we_q) rdata_d[gnt_q] = mem_rdata;
        end else if (tmo_hit) begin
          // Aborted read returns all ones so the master sees a recognisable value.
          state_d        = IDLE;
          ack_d[gnt_q]   = 1'b1;
          if (!mem_we_q) rdata_d[gnt_q] = '1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts an access in flight.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= IW'(CHANNELS - 1);
      gnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef CBM2_BUSARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYCLES - 1);

  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
  logic [CHANNELS-1:0] err_q, err_d;

  // The limit fires in the BUSY cycle where the stall count would reach TMO_CYCLES; mem_ready wins.
  assign tmo_hit = (state_q == BUSY) && !mem_ready && (tmo_cnt_q == TMO_LIM);

  // Stall counter restarts on grant; error flags are sticky until reset.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    if (state_q == IDLE) begin
      if (win_vld) tmo_cnt_d = '0;
    end else if (!mem_ready) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
    if (tmo_hit) err_d[gnt_q] = 1'b1;
  end

  // Timeout registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = '0;
`endif

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cbm2_busarb.sv
// Bench for cbm2_busarb: DUT A round-robin, DUT B fixed priority, both TMO_CYCLES=4.
// Inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Memory responses modelled in the bench; expected acks queued and matched on arrival.
`timescale 1ns/1ps
module tb_cbm2_busarb;
  localparam int CH = 3;
  localparam int AW = 25;
  localparam int DW = 8;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              reset_n;
  logic              sel;        // 0: drive/observe DUT A, 1: DUT B
  logic [CH-1:0]     req, we;
  logic [CH*AW-1:0]  addr;
  logic [CH*DW-1:0]  wdata;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;

  logic [CH-1:0]     req_a, req_b, ack_a, ack_b, err_a, err_b;
  logic [CH*DW-1:0]  rdata_a, rdata_b;
  logic              mem_req_a, mem_req_b, mem_we_a, mem_we_b, rdy_a, rdy_b;
  logic [AW-1:0]     mem_addr_a, mem_addr_b;
  logic [DW-1:0]     mem_wdata_a, mem_wdata_b;

  assign req_a = sel ? '0 : req;
  assign req_b = sel ? req : '0;
  assign rdy_a = sel ? 1'b0 : mem_ready;
  assign rdy_b = sel ? mem_ready : 1'b0;

  logic [CH-1:0]     ack, err;
  logic [CH*DW-1:0]  rdata;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  assign ack       = sel ? ack_b : ack_a;
  assign err       = sel ? err_b : err_a;
  assign rdata     = sel ? rdata_b : rdata_a;
  assign mem_req   = sel ? mem_req_b : mem_req_a;
  assign mem_we    = sel ? mem_we_b : mem_we_a;
  assign mem_addr  = sel ? mem_addr_b : mem_addr_a;
  assign mem_wdata = sel ? mem_wdata_b : mem_wdata_a;

  cbm2_busarb #(.CHANNELS(CH), .AW(AW), .DW(DW), .RR(1), .TMO_CYCLES(4)) u_rr (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_a), .rdata(rdata_a), .err(err_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_ready(rdy_a), .mem_rdata(mem_rdata));

  cbm2_busarb #(.CHANNELS(CH), .AW(AW), .DW(DW), .RR(0), .TMO_CYCLES(4)) u_fp (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_b), .rdata(rdata_b), .err(err_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ready(rdy_b), .mem_rdata(mem_rdata));

  typedef struct {
    int            ch;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            waits;     // wait cycles before mem_ready (large = never)
    logic [DW-1:0] md;        // memory read data
    int            exp_busy;  // cycles mem_req is high
    int            exp_ack;   // cycle of ack, req driven in cycle 0
    logic [DW-1:0] exp_rd;    // rdata[ch] after the access
    logic [CH-1:0] exp_err;
  } vec_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] d;
    int            cyc;
  } sb_t;

  sb_t           sb_q[$];
  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] chan_a [CH];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_of(input logic [CH*DW-1:0] v, input int c);
    return v[c*DW +: DW];
  endfunction

  // One isolated transaction with programmable memory wait states.
  task automatic apply_vec(input vec_t v, input string tag);
    int  cyc = 0;
    int  busy = 0;
    bit  done = 0;
    sb_t e;
    req = '0;
    we  = '0;
    req[v.ch] = 1'b1;
    we[v.ch]  = v.we;
    addr[v.ch*AW +: AW]  = v.a;
    wdata[v.ch*DW +: DW] = v.wd;
    sb_q.push_back('{ch: v.ch, d: v.exp_rd, cyc: v.exp_ack});
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      mem_ready = 1'b0;
      if (mem_req) begin
        busy++;
        check({tag, "_mem_addr"}, mem_addr, v.a);
        check({tag, "_mem_we"}, mem_we, v.we);
        check({tag, "_mem_wdata"}, mem_wdata, v.wd);
        if (busy == v.waits + 1) begin
          mem_ready = 1'b1;
          mem_rdata = v.md;
        end
      end
      if (ack != '0) begin
        e = sb_q.pop_front();
        check({tag, "_ack"}, ack, 64'(1) << e.ch);
        check({tag, "_ack_cycle"}, cyc, e.cyc);
        check({tag, "_rdata"}, rd_of(rdata, e.ch), e.d);
        check({tag, "_err"}, err, v.exp_err);
        req  = '0;
        done = 1;
      end
    end
    mem_ready = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_no_ack: actual=none required=ack by cycle %0d", tag, v.exp_ack);
      sb_q.delete();
    end
    check({tag, "_busy_cycles"}, busy, v.exp_busy);
    tick();
    check({tag, "_post_ack"}, ack, 0);
    check({tag, "_post_mem_req"}, mem_req, 0);
    check({tag, "_post_rdata_hold"}, rd_of(rdata, v.ch), v.exp_rd);
  endtask

  function automatic void push_exp(input int c);
    logic [AW-1:0] a;
    a = chan_a[c];
    sb_q.push_back('{ch: c, d: a[7:0] ^ 8'h5A, cyc: 0});
  endfunction

  // Back-to-back zero-wait traffic; memory returns addr[7:0]^0x5A.
  task automatic stream(input logic [CH-1:0] pat, input int nack, input int drop_at,
                        input logic [CH-1:0] drop_mask, input string tag);
    int  cyc = 0;
    int  acks = 0;
    int  last = 0;
    sb_t e;
    we = '0;
    for (int c = 0; c < CH; c++) addr[c*AW +: AW] = chan_a[c];
    req = pat;
    while (acks < nack && cyc < 100) begin
      tick();
      cyc++;
      mem_ready = 1'b0;
      if (mem_req) begin
        mem_ready = 1'b1;
        mem_rdata = mem_addr[7:0] ^ 8'h5A;
      end
      if (ack != '0) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL %s_extra_ack: actual=%0b required=no ack", tag, ack);
        end else begin
          e = sb_q.pop_front();
          check({tag, "_ack"}, ack, 64'(1) << e.ch);
          check({tag, "_rdata"}, rd_of(rdata, e.ch), e.d);
          check({tag, "_ack_gap"}, cyc - last, 2);
        end
        last = cyc;
        acks++;
        if (acks == drop_at) req = req & ~drop_mask;
        if (acks == nack) req = '0;
      end
    end
    mem_ready = 1'b0;
    if (acks < nack) begin
      total++;
      bad++;
      $display("FAIL %s_stall: actual=%0d acks required=%0d", tag, acks, nack);
      req = '0;
    end
    sb_q.delete();
    tick();
    check({tag, "_idle_ack"}, ack, 0);
    check({tag, "_idle_mem_req"}, mem_req, 0);
  endtask

  vec_t vecs [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tv;
    //            ch we    addr         wdata  wt md     busy ack exp_rd err
    vecs[0] = '{1, 1'b0, 25'h00F1234, 8'h00, 0, 8'h5A, 1, 2, 8'h5A, 3'b000};
    vecs[1] = '{2, 1'b1, 25'h01ABCDE, 8'hC3, 3, 8'hEE, 4, 5, 8'h00, 3'b000};
    vecs[2] = '{0, 1'b0, 25'h0000010, 8'h00, 1, 8'h3C, 2, 3, 8'h3C, 3'b000};
    vecs[3] = '{1, 1'b1, 25'h1FFFFFF, 8'h77, 0, 8'h99, 1, 2, 8'h5A, 3'b000};
    vecs[4] = '{2, 1'b0, 25'h0000000, 8'h00, 2, 8'hA5, 3, 4, 8'hA5, 3'b000};
    vecs[5] = '{0, 1'b0, 25'h1555555, 8'h12, 0, 8'h6E, 1, 2, 8'h6E, 3'b000};
    vecs[6] = '{1, 1'b0, 25'h0AAAAAA, 8'h00, 1, 8'h81, 2, 3, 8'h81, 3'b000};
    chan_a[0] = 25'h00000A1;
    chan_a[1] = 25'h01F0B72;
    chan_a[2] = 25'h00A5C33;

    reset_n = 1'b0; sel = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    check("rst_ack_a", ack_a, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_mem_req_a", mem_req_a, 0);
    check("rst_mem_we_a", mem_we_a, 0);
    check("rst_mem_addr_a", mem_addr_a, 0);
    check("rst_mem_wdata_a", mem_wdata_a, 0);
    check("rst_ack_b", ack_b, 0);
    check("rst_rdata_b", rdata_b, 0);
    check("rst_mem_req_b", mem_req_b, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // mem_ready while idle must not complete anything
    mem_ready = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ready = 1'b0;
    check("idle_ready_ack", ack, 0);
    check("idle_ready_mem_req", mem_req, 0);
    tick();
    check("idle_ready_ack2", ack, 0);
    check("rdata_all_held", rdata, 24'hA5816E);

    // reset during BUSY aborts the access
    req = 3'b001; we = '0; addr[0 +: AW] = 25'h0000123;
    tick();
    check("rstbusy_mem_req", mem_req, 1);
    reset_n = 1'b0; mem_ready = 1'b1; mem_rdata = 8'hDD;
    tick();
    check("rstbusy_ack", ack, 0);
    check("rstbusy_rdata", rdata, 0);
    check("rstbusy_err", err, 0);
    check("rstbusy_mem_req", mem_req, 0);
    check("rstbusy_mem_we", mem_we, 0);
    check("rstbusy_mem_addr", mem_addr, 0);
    check("rstbusy_mem_wdata", mem_wdata, 0);
    reset_n = 1'b1; req = '0; mem_ready = 1'b0;
    tick();
    check("rstbusy_no_late_ack", ack, 0);

    // round-robin: pointer starts at CHANNELS-1
    push_exp(0); push_exp(1); push_exp(2); push_exp(0); push_exp(1); push_exp(2);
    stream(3'b111, 6, 0, 3'b000, "rr_111");
    push_exp(1); push_exp(2); push_exp(1); push_exp(2);
    stream(3'b110, 4, 0, 3'b000, "rr_110");

    // fixed priority on DUT B
    sel = 1'b1;
    tick();
    push_exp(0); push_exp(1); push_exp(0); push_exp(1); push_exp(2);
    stream(3'b111, 5, 4, 3'b001, "fp_111");
    push_exp(0); push_exp(2); push_exp(0); push_exp(2);
    stream(3'b101, 4, 0, 3'b000, "fp_101");
    sel = 1'b0;
    tick();

`ifdef CBM2_BUSARB_TIMEOUT_EN
    tv = '{0, 1'b0, 25'h0000ABC, 8'h00, 3, 8'h21, 4, 5, 8'h21, 3'b000};
    apply_vec(tv, "tmo_ready_at_limit");
    tv = '{0, 1'b0, 25'h0000ABD, 8'h00, 99, 8'h00, 4, 5, 8'hFF, 3'b001};
    apply_vec(tv, "tmo_read");
    tv = '{2, 1'b1, 25'h0000ABE, 8'h05, 99, 8'h00, 4, 5, 8'h69, 3'b101};
    apply_vec(tv, "tmo_write");
    tv = '{1, 1'b0, 25'h0000ABF, 8'h00, 0, 8'h42, 1, 2, 8'h42, 3'b101};
    apply_vec(tv, "tmo_sticky");
`else
    tv = '{1, 1'b0, 25'h0000ABF, 8'h00, 6, 8'h42, 7, 8, 8'h42, 3'b000};
    apply_vec(tv, "long_wait");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
